// File: rtl/dg0045_keydisp_port.sv
// dg0045_keydisp_port: debounced 4x4 key scan onto KIN and ND-strobed nibble capture into display frames
module dg0045_keydisp_port #(
    parameter int DEB_CYCLES = 8,
    parameter int NUM_DIGITS = 8,
    parameter int FRAME_GAP  = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    input  logic [3:0]                        nl_n,
    input  logic                              nd_n,
    input  logic [15:0]                       key_raw,
    output logic [3:0]                        kin,
    output logic [4*NUM_DIGITS-1:0]           disp_data,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   disp_cnt,
    output logic                              frame_done
);
    localparam int DW = $clog2(DEB_CYCLES+1);
    localparam int CW = $clog2(NUM_DIGITS+1);
    localparam int GW = $clog2(FRAME_GAP+1);
    localparam int FW = 4*NUM_DIGITS;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [15:0]   key_s1, key_s2, key_db;
    logic [DW-1:0] deb_cnt [16];
    logic [3:0]    lreg, kin_nx;
    logic          nd_q, strobe, full, expire, commit;
    logic [0:0]    state;
    logic [FW-1:0] wreg, wreg_sh;
    logic [CW-1:0] wcnt, wcnt_inc;
    logic [GW-1:0] gap;

    assign lreg     = ~nl_n;
    assign strobe   = ~nd_q & nd_n;
    assign wreg_sh  = FW'({wreg, lreg});
    assign wcnt_inc = wcnt + CW'(1);
    assign full     = strobe && wcnt_inc == CW'(NUM_DIGITS);
    // a strobe arriving on the expiry cycle keeps the frame open
    assign expire   = !strobe && state == COLLECT && gap == GW'(FRAME_GAP-1);
    assign commit   = full || expire;

    always_comb begin
        kin_nx = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                kin_nx[r] = kin_nx[r] | (lreg[c] & key_db[c*4+r]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            key_s1 <= '0;
            key_s2 <= '0;
            key_db <= '0;
            for (int k = 0; k < 16; k++)
                deb_cnt[k] <= '0;
        end else if (ena) begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            for (int k = 0; k < 16; k++)
                if (key_s2[k] == key_db[k])
                    deb_cnt[k] <= '0;
                else if (deb_cnt[k] == DW'(DEB_CYCLES-1)) begin
                    key_db[k]  <= key_s2[k];
                    deb_cnt[k] <= '0;
                end else
                    deb_cnt[k] <= deb_cnt[k] + DW'(1);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            nd_q       <= 1'b1;
            wreg       <= '0;
            wcnt       <= '0;
            gap        <= '0;
            kin        <= '0;
            disp_data  <= '0;
            disp_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= ena && commit;
            if (ena) begin
                nd_q <= nd_n;
                kin  <= kin_nx;
                if (commit) begin
                    disp_data <= full ? wreg_sh : wreg;
                    disp_cnt  <= full ? wcnt_inc : wcnt;
                    wreg      <= '0;
                    wcnt      <= '0;
                    gap       <= '0;
                    state     <= IDLE;
                end else if (strobe) begin
                    wreg  <= wreg_sh;
                    wcnt  <= wcnt_inc;
                    gap   <= '0;
                    state <= COLLECT;
                end else if (state == COLLECT)
                    gap <= gap + GW'(1);
            end
        end
endmodule

// File: tb/tb_dg0045_keydisp_port.sv
// tb_dg0045_keydisp_port: directed and random stimulus against a queue-based model of key debounce and frame capture
module tb_dg0045_keydisp_port;
    localparam int DEB = 8;
    localparam int ND  = 8;
    localparam int GAP = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [3:0]  nl_n = 4'hE;
    logic        nd_n = 1'b1;
    logic [15:0] key_raw = '0;
    logic [3:0]  kin;
    logic [31:0] disp_data;
    logic [3:0]  disp_cnt;
    logic        frame_done;

    dg0045_keydisp_port dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .nl_n(nl_n), .nd_n(nd_n), .key_raw(key_raw),
        .kin(kin), .disp_data(disp_data), .disp_cnt(disp_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int fd_seen = 0;
    int kin_chg = 0;
    int hold = 0;

    logic [3:0]  m_kin;
    logic [15:0] m_db;
    logic [31:0] m_data;
    int          m_cnt;
    logic        m_fd;
    logic        m_ndq;
    int          idle;
    logic [15:0] rh[$];
    logic [15:0] sh[$];
    logic [3:0]  dig[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_kin = '0; m_db = '0; m_data = '0; m_cnt = 0; m_fd = 1'b0; m_ndq = 1'b1; idle = 0;
        rh.delete(); sh.delete(); dig.delete();
    endtask

    task automatic model_commit();
        m_data = '0;
        foreach (dig[i]) m_data = (m_data << 4) | 32'(dig[i]);
        m_cnt = dig.size();
        m_fd = 1'b1;
        dig.delete();
        idle = 0;
    endtask

    // a key's debounced state flips once its synchronized value has disagreed for DEB consecutive cycles
    task automatic model_edge();
        logic [15:0] syn;
        logic [3:0]  lreg;
        logic        all_diff;
        if (!ena) begin
            m_fd = 1'b0;
            return;
        end
        lreg = ~nl_n;
        m_kin = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (lreg[c] && m_db[c*4+r]) m_kin[r] = 1'b1;
        syn = (rh.size() == 2) ? rh[0] : 16'h0;
        rh.push_back(key_raw);
        if (rh.size() > 2) void'(rh.pop_front());
        sh.push_back(syn);
        if (sh.size() > DEB) void'(sh.pop_front());
        if (sh.size() == DEB)
            for (int k = 0; k < 16; k++) begin
                all_diff = 1'b1;
                foreach (sh[i]) if (sh[i][k] == m_db[k]) all_diff = 1'b0;
                if (all_diff) m_db[k] = ~m_db[k];
            end
        m_fd = 1'b0;
        if (!m_ndq && nd_n) begin
            dig.push_back(lreg);
            idle = 0;
            if (dig.size() == ND) model_commit();
        end else if (dig.size() > 0) begin
            idle++;
            if (idle == GAP) model_commit();
        end
        m_ndq = nd_n;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (frame_done) fd_seen++;
        check("kin", 32'(kin), 32'(m_kin));
        check("disp_data", disp_data, m_data);
        check("disp_cnt", 32'(disp_cnt), 32'(m_cnt));
        check("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic pulse(input logic [3:0] v);
        nl_n = ~v;
        nd_n = 1'b0;
        step();
        nd_n = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_kin", 32'(kin), 0);
        check("reset_disp_data", disp_data, 0);
        check("reset_disp_cnt", 32'(disp_cnt), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        repeat (2) step();

        key_raw = 16'h0040;
        nl_n = 4'hD;
        repeat (DEB+2) step();
        check("kin_early", 32'(kin), 0);
        step();
        check("kin_set", 32'(kin), 32'h4);
        nl_n = 4'hE;
        step();
        check("kin_col_mask", 32'(kin), 0);
        key_raw = 16'h0000;
        repeat (DEB+4) step();

        key_raw = 16'hFFFF;
        nl_n = 4'h0;
        repeat (DEB+3) step();
        check("kin_all", 32'(kin), 32'hF);
        nl_n = 4'hF;
        step();
        check("kin_no_col", 32'(kin), 0);
        key_raw = 16'h0000;
        repeat (DEB+4) step();

        nl_n = 4'hD;
        key_raw = 16'h0040;
        kin_chg = 0;
        repeat (DEB-1) begin
            step();
            if (kin !== 4'h0) kin_chg++;
        end
        key_raw = 16'h0000;
        repeat (3*DEB) begin
            step();
            if (kin !== 4'h0) kin_chg++;
        end
        check("glitch_kin", 32'(kin_chg), 0);

        fd_seen = 0;
        for (int v = 1; v <= 8; v++) pulse(4'(v));
        check("full_fd", 32'(fd_seen), 1);
        check("full_data", disp_data, 32'h12345678);
        check("full_cnt", 32'(disp_cnt), 8);
        step();
        check("full_fd_pulse", 32'(frame_done), 0);

        fd_seen = 0;
        pulse(4'hA); pulse(4'hB); pulse(4'hC);
        repeat (GAP-1) step();
        check("partial_early", 32'(fd_seen), 0);
        step();
        check("partial_fd", 32'(frame_done), 1);
        check("partial_data", disp_data, 32'h00000ABC);
        check("partial_cnt", 32'(disp_cnt), 3);

        fd_seen = 0;
        pulse(4'h5);
        repeat (GAP-2) step();
        pulse(4'h6);
        check("gap_race_fd", 32'(fd_seen), 0);
        repeat (GAP) step();
        check("gap_race_commit", 32'(fd_seen), 1);
        check("gap_race_data", disp_data, 32'h00000056);
        check("gap_race_cnt", 32'(disp_cnt), 2);

        fd_seen = 0;
        pulse(4'h1); pulse(4'h2);
        ena = 1'b0;
        repeat (100) step();
        ena = 1'b1;
        check("ena_hold_fd", 32'(fd_seen), 0);
        for (int v = 3; v <= 8; v++) pulse(4'(v));
        check("ena_resume_fd", 32'(fd_seen), 1);
        check("ena_resume_data", disp_data, 32'h12345678);
        check("ena_resume_cnt", 32'(disp_cnt), 8);

        for (int v = 1; v <= 5; v++) pulse(4'(v));
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_data", disp_data, 0);
        check("midrst_cnt", 32'(disp_cnt), 0);
        repeat (2) step();
        rst_n = 1'b1;
        fd_seen = 0;
        for (int v = 15; v >= 8; v--) pulse(4'(v));
        check("midrst_fd", 32'(fd_seen), 1);
        check("midrst_frame", disp_data, 32'hFEDCBA98);
        check("midrst_frame_cnt", 32'(disp_cnt), 8);

        repeat (3000) begin
            ena = ($urandom_range(0, 9) != 0);
            nl_n = 4'($urandom);
            nd_n = ($urandom_range(0, 24) != 0);
            if (hold == 0) begin
                key_raw = 16'($urandom);
                hold = $urandom_range(1, 16);
            end else
                hold--;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
